// File: rtl/step_sequencer_pkg.sv
// Shared types and default widths for the microstep sequencer.
package step_sequencer_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } seq_state_t;

    localparam int DEF_INSTRUCTION_WIDTH = 4;
    localparam int DEF_INSTRUCTION_STEPS = 8;
    localparam int DEF_BUS_WIDTH         = 8;

endpackage

// File: rtl/step_sequencer_flag_register.sv
// Three-bit load-enabled latch for the ALU zero/carry/odd flags.
module flag_register (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 3'b000;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Microstep sequencer with instruction register and latched ALU flags.
// Optional SEQ_RESUME_EN adds i_resume to leave HALTED without a reset.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int INSTRUCTION_STEPS = DEF_INSTRUCTION_STEPS,
    parameter int BUS_WIDTH         = DEF_BUS_WIDTH,
    localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
    localparam int OPERAND_WIDTH    = BUS_WIDTH - INSTRUCTION_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [BUS_WIDTH-1:0]         i_bus,
    input  logic                         i_instrregi,
    input  logic                         i_alulatchf,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    input  logic                         i_adv,
    input  logic                         i_halt,
`ifdef SEQ_RESUME_EN
    input  logic                         i_resume,
`endif
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [OPERAND_WIDTH-1:0]     o_operand,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic                         o_halted,
    output logic                         o_step_overflow
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    seq_state_t                   state_q, state_d;
    logic [STEP_WIDTH-1:0]        step_q, step_d;
    logic                         overflow_q, overflow_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q;
    logic [OPERAND_WIDTH-1:0]     operand_q;
    logic                         instr_load;
    logic                         flag_load;
    logic [2:0]                   flags_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= RUN;
            step_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            overflow_q <= overflow_d;
        end
    end

    // Halt wins over both advance and wrap; loads still land in the halting cycle.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        overflow_d = overflow_q;
        instr_load = 1'b0;
        flag_load  = 1'b0;
        case (state_q)
            RUN: begin
                instr_load = i_instrregi;
                flag_load  = i_alulatchf;
                if (i_halt) begin
                    state_d = HALTED;
                end else if (i_adv) begin
                    step_d = '0;
                end else if (step_q == LAST_STEP) begin
                    step_d     = '0;
                    overflow_d = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            HALTED: begin
`ifdef SEQ_RESUME_EN
                if (i_resume) begin
                    state_d = RUN;
                    step_d  = '0;
                end
`endif
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_q   <= '0;
            operand_q <= '0;
        end else if (instr_load) begin
            instr_q   <= i_bus[BUS_WIDTH-1:OPERAND_WIDTH];
            operand_q <= i_bus[OPERAND_WIDTH-1:0];
        end
    end

    flag_register u_flags (
        .clk   (i_clk),
        .reset (i_reset),
        .load  (flag_load),
        .d     ({i_alu_zero, i_alu_carry, i_alu_odd}),
        .q     (flags_q)
    );

    assign o_step          = step_q;
    assign o_instruction   = instr_q;
    assign o_operand       = operand_q;
    assign o_zero          = flags_q[2];
    assign o_carry         = flags_q[1];
    assign o_odd           = flags_q[0];
    assign o_halted        = (state_q == HALTED);
    assign o_step_overflow = overflow_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus randomized traffic against a reference model.
module tb_step_sequencer;

    localparam int IW    = 4;
    localparam int STEPS = 8;
    localparam int BW    = 8;
    localparam int SW    = $clog2(STEPS);
    localparam int OPW   = BW - IW;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic [BW-1:0] i_bus = '0;
    logic          i_instrregi = 1'b0;
    logic          i_alulatchf = 1'b0;
    logic          i_alu_zero = 1'b0;
    logic          i_alu_carry = 1'b0;
    logic          i_alu_odd = 1'b0;
    logic          i_adv = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_resume = 1'b0;
    logic [SW-1:0]  o_step;
    logic [IW-1:0]  o_instruction;
    logic [OPW-1:0] o_operand;
    logic           o_zero, o_carry, o_odd, o_halted, o_step_overflow;

    step_sequencer dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_bus           (i_bus),
        .i_instrregi     (i_instrregi),
        .i_alulatchf     (i_alulatchf),
        .i_alu_zero      (i_alu_zero),
        .i_alu_carry     (i_alu_carry),
        .i_alu_odd       (i_alu_odd),
        .i_adv           (i_adv),
        .i_halt          (i_halt),
`ifdef SEQ_RESUME_EN
        .i_resume        (i_resume),
`endif
        .o_step          (o_step),
        .o_instruction   (o_instruction),
        .o_operand       (o_operand),
        .o_zero          (o_zero),
        .o_carry         (o_carry),
        .o_odd           (o_odd),
        .o_halted        (o_halted),
        .o_step_overflow (o_step_overflow)
    );

    // Clock and reset-free free-running clock
    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Reference model: plain integers advanced by the behavioural rules
    int m_step = 0, m_instr = 0, m_oper = 0, m_zero = 0, m_carry = 0, m_odd = 0;
    int m_halted = 0, m_ovf = 0;

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_step = 0; m_instr = 0; m_oper = 0; m_zero = 0; m_carry = 0; m_odd = 0;
            m_halted = 0; m_ovf = 0;
        end else if (m_halted == 0) begin
            if (i_instrregi) begin
                m_instr = int'(i_bus) / (1 << OPW);
                m_oper  = int'(i_bus) % (1 << OPW);
            end
            if (i_alulatchf) begin
                m_zero = int'(i_alu_zero); m_carry = int'(i_alu_carry); m_odd = int'(i_alu_odd);
            end
            if (i_halt) m_halted = 1;
            else if (i_adv) m_step = 0;
            else begin
                if (m_step + 1 == STEPS) m_ovf = 1;
                m_step = (m_step + 1) % STEPS;
            end
        end else begin
`ifdef SEQ_RESUME_EN
            if (i_resume) begin
                m_halted = 0;
                m_step = 0;
            end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT against model, away from the active edge
    always @(negedge i_clk) begin
        if (check_en) begin
            vectors++;
            chk("step", int'(o_step), m_step);
            chk("instruction", int'(o_instruction), m_instr);
            chk("operand", int'(o_operand), m_oper);
            chk("zero", int'(o_zero), m_zero);
            chk("carry", int'(o_carry), m_carry);
            chk("odd", int'(o_odd), m_odd);
            chk("halted", int'(o_halted), m_halted);
            chk("overflow", int'(o_step_overflow), m_ovf);
        end
    end

    // Hand-computed literal expectation that pins the model
    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        chk(name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        check_en = 1'b1;

        // Idle counting after reset
        lit("reset_step", int'(o_step), 0);
        lit("reset_halted", int'(o_halted), 0);
        lit("reset_others", int'({o_instruction, o_operand, o_zero, o_carry, o_odd, o_step_overflow}), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            lit("idle_step", int'(o_step), k);
        end

        // Instruction load then advance
        do_reset();
        tick();
        i_bus = 8'h2C; i_instrregi = 1'b1;
        tick();
        i_instrregi = 1'b0; i_bus = 8'h00;
        lit("load_step", int'(o_step), 2);
        tick(); tick(); tick();
        lit("pre_adv_step", int'(o_step), 5);
        i_adv = 1'b1;
        tick();
        i_adv = 1'b0;
        lit("adv_step", int'(o_step), 0);
        lit("opcode", int'(o_instruction), 4'h2);
        lit("operand", int'(o_operand), 4'hC);

        // Wrap without advance sets the sticky flag
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        lit("wrap_step", int'(o_step), 2);
        lit("wrap_ovf", int'(o_step_overflow), 1);
        do_reset();
        lit("ovf_cleared", int'(o_step_overflow), 0);

        // Flag latching
        i_alu_zero = 1'b1; i_alu_carry = 1'b1; i_alu_odd = 1'b0; i_alulatchf = 1'b1;
        tick();
        i_alulatchf = 1'b0;
        lit("flags_latched", int'({o_zero, o_carry, o_odd}), 3'b110);
        i_alu_zero = 1'b0; i_alu_carry = 1'b0; i_alu_odd = 1'b1;
        tick();
        lit("flags_held", int'({o_zero, o_carry, o_odd}), 3'b110);

        // Halt beats advance; loads ignored while halted
        do_reset();
        tick(); tick(); tick();
        i_halt = 1'b1; i_adv = 1'b1;
        tick();
        i_halt = 1'b0; i_adv = 1'b0;
        lit("halt_step", int'(o_step), 3);
        lit("halt_state", int'(o_halted), 1);
        i_bus = 8'hF1; i_instrregi = 1'b1; i_alulatchf = 1'b1; i_alu_zero = 1'b1;
        tick(); tick();
        i_instrregi = 1'b0; i_alulatchf = 1'b0;
        lit("halt_ignore_instr", int'(o_instruction), 0);
        lit("halt_ignore_flags", int'(o_zero), 0);
        lit("halt_hold_step", int'(o_step), 3);
        do_reset();
        lit("halt_reset_step", int'(o_step), 0);
        lit("halt_reset_state", int'(o_halted), 0);

`ifdef SEQ_RESUME_EN
        // Resume from halt keeps opcode
        i_bus = 8'h5A; i_instrregi = 1'b1;
        tick();
        i_instrregi = 1'b0;
        tick();
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        lit("resume_halted", int'(o_halted), 1);
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        lit("resume_state", int'(o_halted), 0);
        lit("resume_step", int'(o_step), 0);
        lit("resume_opcode", int'(o_instruction), 4'h5);
`endif

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 600; n++) begin
            i_reset     = ($urandom_range(0, 63) == 0);
            i_halt      = ($urandom_range(0, 15) == 0);
            i_adv       = ($urandom_range(0, 3) == 0);
            i_resume    = ($urandom_range(0, 7) == 0);
            i_instrregi = ($urandom_range(0, 2) == 0);
            i_alulatchf = ($urandom_range(0, 2) == 0);
            i_bus       = BW'($urandom_range(0, (1 << BW) - 1));
            i_alu_zero  = $urandom_range(0, 1) == 1;
            i_alu_carry = $urandom_range(0, 1) == 1;
            i_alu_odd   = $urandom_range(0, 1) == 1;
            tick();
        end
        i_reset = 1'b0; i_halt = 1'b0; i_adv = 1'b0; i_resume = 1'b0;
        i_instrregi = 1'b0; i_alulatchf = 1'b0;
        tick();
        @(negedge i_clk);
        #1;
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: Step_Sequencer

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 4, opcode width.
REQ-002 SHALL have parameter INSTRUCTION_STEPS, default 8, microsteps per instruction; STEP_WIDTH = $clog2(INSTRUCTION_STEPS).
REQ-003 SHALL have parameter BUS_WIDTH, default 8, data bus width; operand width = BUS_WIDTH-INSTRUCTION_WIDTH.
REQ-004 Ports SHALL be:
- i_clk  in  1  sole clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_bus  in  BUS_WIDTH  data bus value
- i_instrregi  in  1  load instruction register from i_bus
- i_alulatchf  in  1  latch ALU flags
- i_alu_zero / i_alu_carry / i_alu_odd  in  1 each  live ALU flags
- i_adv  in  1  end current instruction
- i_halt  in  1  halt request
- o_step  out  STEP_WIDTH  current microstep
- o_instruction  out  INSTRUCTION_WIDTH  opcode, i_bus upper bits
- o_operand  out  BUS_WIDTH-INSTRUCTION_WIDTH  operand, i_bus lower bits
- o_zero / o_carry / o_odd  out  1 each  latched flags
- o_halted  out  1  sequencer in HALTED
- o_step_overflow  out  1  sticky: step wrapped without i_adv

Function
REQ-005 SHALL implement two states: RUN, HALTED.
REQ-006 In RUN, o_step SHALL increment by 1 each cycle unless i_adv or i_halt is high.
REQ-007 In RUN with i_adv=1 and i_halt=0, o_step SHALL be 0 next cycle.
REQ-008 In RUN with o_step=INSTRUCTION_STEPS-1 and i_adv=0, o_step SHALL wrap to 0 and o_step_overflow SHALL set.
REQ-009 In RUN with i_halt=1, the next state SHALL be HALTED and o_step SHALL hold; i_halt SHALL take priority over i_adv and wrap.
REQ-010 In HALTED, o_step, o_instruction, o_operand and flags SHALL hold; i_adv, i_instrregi and i_alulatchf SHALL be ignored.
REQ-011 When i_instrregi=1 in RUN, o_instruction SHALL load i_bus[BUS_WIDTH-1:BUS_WIDTH-INSTRUCTION_WIDTH] and o_operand SHALL load the remaining low bits, both visible the next cycle.
REQ-012 When i_alulatchf=1 in RUN, o_zero/o_carry/o_odd SHALL load the i_alu_* values, visible the next cycle; otherwise they hold.
REQ-013 i_instrregi, i_alulatchf and i_adv in the same cycle SHALL all take effect.
REQ-014 o_halted SHALL be 1 exactly when the state is HALTED, registered.
REQ-015 o_step_overflow SHALL stay set until reset.
REQ-016 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-017 When i_reset=1 at a rising edge, the state SHALL become RUN and every output SHALL become 0, overriding all other inputs in that cycle, including mid-instruction and in HALTED.

Configuration
REQ-018 With SEQ_RESUME_EN defined, there SHALL be an extra input i_resume (1 bit). i_resume=1 in HALTED SHALL give RUN with o_step=0 next cycle, with opcode, operand and flags retained. i_resume in RUN SHALL be ignored.
REQ-019 Without SEQ_RESUME_EN, i_resume SHALL not exist and HALTED SHALL be left only by reset.

Structure
REQ-020 A shared package SHALL hold the RUN/HALTED state enum and the default widths (4, 8, 8).
REQ-021 A sub-module Flag_Register SHALL implement the three-bit load-enabled flag latch. The step counter and instruction register SHALL stay inline.

Verification
REQ-022 Reset, then 5 idle cycles -> o_step = 0,1,2,3,4,5; o_halted=0; other outputs 0.
REQ-023 i_bus=8'h2C with i_instrregi at step 1, then i_adv at step 5 -> o_instruction=4'h2, o_operand=4'hC; o_step goes 5->0.
REQ-024 10 cycles with no i_adv -> o_step wraps 7->0 and o_step_overflow=1 persists; reset clears it.
REQ-025 i_alulatchf with zero=1, carry=1, odd=0 -> flags 1,1,0 next cycle; ALU inputs changed without latch -> flags unchanged.
REQ-026 i_halt and i_adv together at step 3 -> HALTED, o_step stays 3, later i_instrregi is ignored; i_reset -> step 0, RUN.
REQ-027 With SEQ_RESUME_EN, halt at step 2, then i_resume -> o_halted=0 and o_step=0 next cycle, opcode retained.
